// File: rtl/pwm_pkg.sv
// Shared constants and helpers for the eight-channel tone generator and mixer.
package pwm_pkg;

  localparam int NUM_CH  = 8;
  localparam int CNT_W   = 16;
  localparam int MIX_W   = 4;
  localparam int FRAME_W = 3;

  // Number of tone bits that are currently high; feeds the mixer level.
  function automatic logic [MIX_W-1:0] popcount(input logic [NUM_CH-1:0] bits);
    logic [MIX_W-1:0] total;
    total = {MIX_W{1'b0}};
    for (int i = 0; i < NUM_CH; i++) begin
      total = total + {{(MIX_W-1){1'b0}}, bits[i]};
    end
    return total;
  endfunction

endpackage

// File: rtl/pwm_tone_channel.sv
// One square-wave tone channel: half-period counter, tone flip-flop and a
// completion pulse on every falling edge of the tone.
module pwm_tone_channel #(
  parameter int CNT_W = pwm_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [CNT_W-1:0] half_period,
  output logic             tone,
  output logic             period_done
);
  import pwm_pkg::*;

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             active;
  logic             active_next;
  logic             tone_next;
  logic             done_next;
  logic             reg_zero;

  // The live register is only consulted at a load or a half-period boundary.
  assign reg_zero = (half_period == CNT_ZERO);

  // Next-state rules: disable wins over everything, then load, count, boundary.
  always_comb begin
    cnt_next    = cnt;
    active_next = active;
    tone_next   = tone;
    done_next   = 1'b0;
    if (!enable) begin
      cnt_next    = CNT_ZERO;
      active_next = 1'b0;
      tone_next   = 1'b0;
      done_next   = tone;
    end else if (!active) begin
      if (!reg_zero) begin
        cnt_next    = half_period - CNT_ONE;
        active_next = 1'b1;
      end else begin
        cnt_next    = cnt;
      end
    end else if (cnt != CNT_ZERO) begin
      cnt_next = cnt - CNT_ONE;
    end else if (!reg_zero) begin
      tone_next = ~tone;
      cnt_next  = half_period - CNT_ONE;
      done_next = tone;
    end else begin
      tone_next   = 1'b0;
      active_next = 1'b0;
      done_next   = tone;
    end
  end

  // Channel state register; reset clears without producing a completion pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= CNT_ZERO;
      active      <= 1'b0;
      tone        <= 1'b0;
      period_done <= 1'b0;
    end else begin
      cnt         <= cnt_next;
      active      <= active_next;
      tone        <= tone_next;
      period_done <= done_next;
    end
  end

endmodule

// File: rtl/pwm_tone_bank.sv
// Eight tone channels plus a popcount mixer that turns the number of high
// tones into a 1-bit PWM stream over an 8-cycle frame.
module pwm_tone_bank #(
  parameter int NUM_CH = pwm_pkg::NUM_CH,
  parameter int CNT_W  = pwm_pkg::CNT_W,
  parameter int MIX_W  = pwm_pkg::MIX_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [CNT_W-1:0]  pwm_reg0,
  input  logic [CNT_W-1:0]  pwm_reg1,
  input  logic [CNT_W-1:0]  pwm_reg2,
  input  logic [CNT_W-1:0]  pwm_reg3,
  input  logic [CNT_W-1:0]  pwm_reg4,
  input  logic [CNT_W-1:0]  pwm_reg5,
  input  logic [CNT_W-1:0]  pwm_reg6,
  input  logic [CNT_W-1:0]  pwm_reg7,
  output logic [NUM_CH-1:0] tone_out,
  output logic [NUM_CH-1:0] period_done,
  output logic [MIX_W-1:0]  mix_level,
  output logic              audio_pwm
);
  import pwm_pkg::*;

  logic [CNT_W-1:0]   half_period [NUM_CH];
  logic [FRAME_W-1:0] frame_cnt;
  logic [MIX_W-1:0]   level_hold;

  assign half_period[0] = pwm_reg0;
  assign half_period[1] = pwm_reg1;
  assign half_period[2] = pwm_reg2;
  assign half_period[3] = pwm_reg3;
  assign half_period[4] = pwm_reg4;
  assign half_period[5] = pwm_reg5;
  assign half_period[6] = pwm_reg6;
  assign half_period[7] = pwm_reg7;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    pwm_tone_channel #(.CNT_W(CNT_W)) u_ch (
      .clk         (clk),
      .rst         (rst),
      .enable      (enable),
      .half_period (half_period[i]),
      .tone        (tone_out[i]),
      .period_done (period_done[i])
    );
  end

  // Mixer: level is sampled once per frame so the duty cycle never tears mid-frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      mix_level  <= {MIX_W{1'b0}};
      frame_cnt  <= {FRAME_W{1'b0}};
      level_hold <= {MIX_W{1'b0}};
      audio_pwm  <= 1'b0;
    end else begin
      mix_level <= popcount(tone_out);
      frame_cnt <= frame_cnt + {{(FRAME_W-1){1'b0}}, 1'b1};
      if (frame_cnt == {FRAME_W{1'b0}}) begin
        level_hold <= mix_level;
      end else begin
        level_hold <= level_hold;
      end
      audio_pwm <= ({1'b0, frame_cnt} < level_hold);
    end
  end

endmodule

// File: tb/tb_pwm_tone_bank.sv
// Self-checking bench for pwm_tone_bank: timestamp-based behavioural model,
// per-cycle compare, directed literal checks and a randomized phase.
module tb_pwm_tone_bank;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [15:0] regs_tb [8];
  logic [7:0]  tone_out;
  logic [7:0]  period_done;
  logic [3:0]  mix_level;
  logic        audio_pwm;

  int checks   = 0;
  int failures = 0;
  bit checking = 1'b0;
  int rel      = 0;

  // Behavioural model: each channel remembers the absolute cycle of its next boundary.
  bit     m_tone   [8];
  bit     m_active [8];
  bit     m_pd     [8];
  longint m_next   [8];
  int     m_mix    = 0;
  int     m_frame  = 0;
  int     m_hold   = 0;
  bit     m_audio  = 1'b0;
  longint cyc      = 0;

  pwm_tone_bank dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .pwm_reg0    (regs_tb[0]),
    .pwm_reg1    (regs_tb[1]),
    .pwm_reg2    (regs_tb[2]),
    .pwm_reg3    (regs_tb[3]),
    .pwm_reg4    (regs_tb[4]),
    .pwm_reg5    (regs_tb[5]),
    .pwm_reg6    (regs_tb[6]),
    .pwm_reg7    (regs_tb[7]),
    .tone_out    (tone_out),
    .period_done (period_done),
    .mix_level   (mix_level),
    .audio_pwm   (audio_pwm)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic adv(input int target);
    while (rel < target) begin
      @(negedge clk);
      rel++;
    end
  endtask

  // Model update at every rising edge from the inputs held stable since the falling edge.
  initial begin
    bit [7:0] tv;
    forever begin
      @(posedge clk);
      cyc++;
      if (rst) begin
        for (int i = 0; i < 8; i++) begin
          m_tone[i] = 0; m_active[i] = 0; m_pd[i] = 0; m_next[i] = 0;
        end
        m_mix = 0; m_frame = 0; m_hold = 0; m_audio = 0;
      end else begin
        tv = '0;
        for (int i = 0; i < 8; i++) tv[i] = m_tone[i];
        for (int i = 0; i < 8; i++) begin
          automatic int rv = int'(regs_tb[i]);
          m_pd[i] = 0;
          if (!enable) begin
            m_pd[i] = m_tone[i]; m_tone[i] = 0; m_active[i] = 0;
          end else if (!m_active[i]) begin
            if (rv != 0) begin
              m_active[i] = 1; m_next[i] = cyc + rv;
            end
          end else if (cyc == m_next[i]) begin
            m_pd[i] = m_tone[i];
            if (rv != 0) begin
              m_tone[i] = !m_tone[i]; m_next[i] = cyc + rv;
            end else begin
              m_tone[i] = 0; m_active[i] = 0;
            end
          end
        end
        m_audio = (m_frame < m_hold);
        if (m_frame == 0) m_hold = m_mix;
        m_frame = (m_frame + 1) % 8;
        m_mix = $countones(tv);
      end
    end
  end

  // Compare every output against the model on each falling edge.
  initial begin
    logic [7:0] et, ep;
    forever begin
      @(negedge clk);
      if (checking) begin
        for (int i = 0; i < 8; i++) begin
          et[i] = m_tone[i]; ep[i] = m_pd[i];
        end
        chk("model_tone_out", tone_out, et);
        chk("model_period_done", period_done, ep);
        chk("model_mix_level", mix_level, m_mix);
        chk("model_audio_pwm", audio_pwm, m_audio);
      end
    end
  end

  initial begin
    logic [7:0] prev;
    int hi;
    rst = 1'b1;
    enable = 1'b0;
    for (int i = 0; i < 8; i++) regs_tb[i] = 16'($urandom);
    @(negedge clk);
    checking = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("reset_tone", tone_out, 0);
    chk("reset_done", period_done, 0);
    chk("reset_mix", mix_level, 0);
    chk("reset_audio", audio_pwm, 0);

    for (int i = 0; i < 8; i++) regs_tb[i] = 16'd0;
    rst = 1'b0;
    enable = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      chk("idle_tone", tone_out, 0);
      chk("idle_audio", audio_pwm, 0);
    end

    // Basic tone, then glitch-free retune and forced silence on channel 0.
    regs_tb[0] = 16'd3; rel = 0;
    adv(3);  chk("basic_pre_rise", tone_out[0], 0);
    adv(4);  chk("basic_rise_t3", tone_out[0], 1);
    adv(6);  chk("basic_high_t5", tone_out[0], 1);
    adv(7);  chk("basic_fall_t6", tone_out[0], 0); chk("basic_done_t6", period_done[0], 1);
    adv(8);  chk("basic_done_once", period_done[0], 0);
    adv(10); chk("basic_rise_t9", tone_out[0], 1);
    regs_tb[0] = 16'd5;
    adv(12); chk("retune_high_t11", tone_out[0], 1);
    adv(13); chk("retune_fall_t12", tone_out[0], 0); chk("retune_done_t12", period_done[0], 1);
    adv(17); chk("retune_low_t16", tone_out[0], 0);
    adv(18); chk("retune_rise_t17", tone_out[0], 1);
    adv(22); chk("retune_high_t21", tone_out[0], 1);
    adv(23); chk("retune_fall_t22", tone_out[0], 0); chk("retune_done_t22", period_done[0], 1);
    adv(29); chk("silence_high_t28", tone_out[0], 1);
    regs_tb[0] = 16'd0;
    adv(32); chk("silence_hold_t31", tone_out[0], 1);
    adv(33); chk("silence_fall_t32", tone_out[0], 0); chk("silence_done_t32", period_done[0], 1);
    adv(45); chk("silence_idle", tone_out[0], 0);

    // Minimum period on channel 1.
    regs_tb[1] = 16'd1; rel = 0;
    adv(2); chk("min_rise", tone_out[1], 1); chk("min_nodone", period_done[1], 0);
    adv(3); chk("min_fall", tone_out[1], 0); chk("min_done", period_done[1], 1);
    adv(4); chk("min_rise2", tone_out[1], 1);
    adv(5); chk("min_done2", period_done[1], 1);
    regs_tb[1] = 16'd0;
    adv(10);

    // All eight channels at reg=4 loaded on the same edge.
    enable = 1'b0;
    @(negedge clk);
    enable = 1'b1;
    for (int i = 0; i < 8; i++) regs_tb[i] = 16'd4;
    rel = 0;
    adv(6);  chk("mix8_t5", mix_level, 8);
    adv(9);  chk("mix8_t8", mix_level, 8);
    adv(10); chk("mix0_t9", mix_level, 0);
    adv(13); chk("mix0_t12", mix_level, 0);
    adv(14); chk("mix8_t13", mix_level, 8);

    // Three channels held high long enough for the duty cycle to settle.
    enable = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 8; i++) regs_tb[i] = (i < 3) ? 16'd1000 : 16'd0;
    enable = 1'b1;
    rel = 0;
    adv(1020);
    chk("mix3_level", mix_level, 3);
    hi = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      hi += int'(audio_pwm);
    end
    chk("mix3_duty", hi, 3);

    // Drop enable with five channels running.
    enable = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 8; i++) regs_tb[i] = (i < 5) ? 16'(7 + 2 * i) : 16'd0;
    enable = 1'b1;
    repeat ($urandom_range(30, 80)) @(negedge clk);
    prev = tone_out;
    enable = 1'b0;
    @(negedge clk);
    chk("disable_tone", tone_out, 0);
    chk("disable_done", period_done, prev);

    // Same again, but stopped by reset: no completion pulses.
    enable = 1'b1;
    repeat ($urandom_range(40, 90)) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_tone", tone_out, 0);
    chk("rst_done", period_done, 0);
    chk("rst_mix", mix_level, 0);
    chk("rst_audio", audio_pwm, 0);
    rst = 1'b0;

    // Randomized phase: register writes, enable toggles and occasional reset.
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      rst = 1'b0;
      if ($urandom_range(0, 15) == 0) regs_tb[$urandom_range(0, 7)] = 16'($urandom_range(0, 12));
      if ($urandom_range(0, 199) == 0) enable = ~enable;
      if ($urandom_range(0, 499) == 0) rst = 1'b1;
    end
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
